// File: rtl/sb_3320_color_sensor_emulator.sv
// sb_3320_color_sensor_emulator
//
// Behavioural, synthesizable stand-in for a TCS3200 colour sensor. It sits on
// the sensor side of the S0-S3 / OUT interface. It turns the scaling and filter
// pins into a square wave on OUT. The wave's half-period comes from one of four
// programmable registers.
//
// Ports
//   clk50       in   50 MHz system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   S0, S1      in   frequency scaling (00 off, 01 2%, 10 20%, 11 100%), async
//   S2, S3      in   filter select (00 red, 01 blue, 10 clear, 11 green), async
//   OUT         out  emulated frequency output, registered
//   cfg_we      in   single-cycle write strobe for a half-period register
//   cfg_sel     in   register select, same coding as {S2,S3}
//   cfg_data    in   half-period in clk50 cycles at 100% scale (0 = dark)
//   edge_clr    in   synchronous clear of edge_count
//   edge_count  out  OUT rising edges since reset/clear, wraps
//   state_o     out  FSM state: 0 OFF, 1 SETTLE, 2 RUN
//
// State   | meaning
// --------+----------------------------------------------------------
// OFF     | power-down (S0S1 = 00), OUT low, counters held at zero
// SETTLE  | pins just changed, OUT held low for SETTLE_CYC cycles
// RUN     | OUT toggles every lim cycles, lim re-latched at each toggle

module sb_3320_color_sensor_emulator #(
  parameter int unsigned SETTLE_CYC     = 100,
  parameter logic [15:0] DEF_RED_HALF   = 16'd200,
  parameter logic [15:0] DEF_GREEN_HALF = 16'd250,
  parameter logic [15:0] DEF_BLUE_HALF  = 16'd150,
  parameter logic [15:0] DEF_CLEAR_HALF = 16'd80
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic        S0,
  input  logic        S1,
  input  logic        S2,
  input  logic        S3,
  output logic        OUT,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_sel,
  input  logic [15:0] cfg_data,
  input  logic        edge_clr,
  output logic [15:0] edge_count,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);

  state_t      state_q;
  logic [3:0]  meta_q;
  logic [3:0]  sel_s_q;
  logic [3:0]  sel_q;
  logic [15:0] half_q [4];
  logic [15:0] settle_q;
  logic [21:0] cnt_q;
  logic [21:0] lim_q;
  logic        out_q;
  logic [15:0] edge_q;

  logic        chg;
  logic [15:0] half_sel;
  logic [21:0] half_ext;
  logic [21:0] scaled_lim;
  logic        toggle;
  logic        rise;

  // Two-flop synchronizer for the asynchronous pins, bit order {S0,S1,S2,S3}.
  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      meta_q  <= 4'b0000;
      sel_s_q <= 4'b0000;
    end else begin
      meta_q  <= {S0, S1, S2, S3};
      sel_s_q <= meta_q;
    end
  end

  // Half-period registers, indexed by the filter code.
  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      half_q[0] <= DEF_RED_HALF;
      half_q[1] <= DEF_BLUE_HALF;
      half_q[2] <= DEF_CLEAR_HALF;
      half_q[3] <= DEF_GREEN_HALF;
    end else if (cfg_we) begin
      half_q[cfg_sel] <= cfg_data;
    end
  end

  assign chg      = (sel_s_q != sel_q);
  assign half_sel = half_q[sel_s_q[1:0]];
  assign half_ext = {6'd0, half_sel};

  // Slower output scales stretch the half-period; shift-add keeps this
  // multiplier-free.
  always_comb begin
    scaled_lim = '0;
    case (sel_s_q[3:2])
      2'b11:   scaled_lim = half_ext;
      2'b10:   scaled_lim = (half_ext << 2) + half_ext;
      2'b01:   scaled_lim = (half_ext << 5) + (half_ext << 4) + (half_ext << 1);
      default: scaled_lim = '0;
    endcase
  end

  assign toggle = (state_q == ST_RUN) && (sel_s_q[3:2] != 2'b00) && !chg &&
                  (lim_q != 22'd0) && (cnt_q == lim_q - 22'd1);
  assign rise   = toggle && !out_q;

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      state_q  <= ST_OFF;
      sel_q    <= 4'b0000;
      settle_q <= '0;
      cnt_q    <= '0;
      lim_q    <= '0;
      out_q    <= 1'b0;
    end else begin
      sel_q <= sel_s_q;
      if (sel_s_q[3:2] == 2'b00) begin
        state_q  <= ST_OFF;
        out_q    <= 1'b0;
        cnt_q    <= '0;
        settle_q <= '0;
      end else if (chg || state_q == ST_OFF) begin
        state_q  <= ST_SETTLE;
        out_q    <= 1'b0;
        cnt_q    <= '0;
        settle_q <= '0;
      end else begin
        case (state_q)
          ST_SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
              state_q <= ST_RUN;
              cnt_q   <= '0;
              lim_q   <= scaled_lim;
            end else begin
              settle_q <= settle_q + 16'd1;
            end
          end
          ST_RUN: begin
            if (lim_q == 22'd0) begin
              // Dark channel: keep polling the register so a later write wakes it.
              out_q <= 1'b0;
              cnt_q <= '0;
              lim_q <= scaled_lim;
            end else if (toggle) begin
              // New half-period value is only picked up here, so a write
              // never truncates the phase in progress.
              out_q <= ~out_q;
              cnt_q <= '0;
              lim_q <= scaled_lim;
            end else begin
              cnt_q <= cnt_q + 22'd1;
            end
          end
          default: state_q <= ST_OFF;
        endcase
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      edge_q <= '0;
    end else if (edge_clr) begin
      edge_q <= '0;
    end else if (rise) begin
      edge_q <= edge_q + 16'd1;
    end
  end

  assign OUT        = out_q;
  assign edge_count = edge_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_sb_3320_color_sensor_emulator.sv
module tb_sb_3320_color_sensor_emulator;

  logic        clk50 = 1'b0;
  logic        rst_n;
  logic        S0, S1, S2, S3;
  logic        OUT;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_data;
  logic        edge_clr;
  logic [15:0] edge_count;
  logic [1:0]  state_o;

  int tests  = 0;
  int failed = 0;

  always #10 clk50 = ~clk50;

  sb_3320_color_sensor_emulator dut (
    .clk50      (clk50),
    .rst_n      (rst_n),
    .S0         (S0),
    .S1         (S1),
    .S2         (S2),
    .S3         (S3),
    .OUT        (OUT),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .edge_clr   (edge_clr),
    .edge_count (edge_count),
    .state_o    (state_o)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_pins(input logic [3:0] s);
    {S0, S1, S2, S3} = s;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [15:0] data);
    cfg_sel  = sel;
    cfg_data = data;
    cfg_we   = 1'b1;
    tick(1);
    cfg_we   = 1'b0;
  endtask

  // Cycles until OUT reaches lvl; a timeout counts as a failed comparison.
  task automatic wait_level(input string tag, input logic lvl, input int budget, output int n);
    n = 0;
    while (OUT !== lvl && n < budget) begin
      tick(1);
      n++;
    end
    if (OUT !== lvl) begin
      tests++;
      failed++;
      $error("FAIL %s_timeout: observed OUT %b expected %b within %0d cycles", tag, OUT, lvl, budget);
    end
  endtask

  // Change pins, check the 3-cycle latency, the 100-cycle settle and one full period.
  task automatic run_channel(input string tag, input logic [3:0] s, input int half);
    int n;
    set_pins(s);
    tick(3);
    check({tag, "_settle_state"}, state_o, 1);
    check({tag, "_settle_out"}, OUT, 0);
    tick(100);
    check({tag, "_run_state"}, state_o, 2);
    wait_level({tag, "_first_rise"}, 1'b1, 4000, n);
    check({tag, "_first_rise"}, n, half);
    wait_level({tag, "_high"}, 1'b0, 4000, n);
    check({tag, "_high"}, n, half);
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    cfg_we   = 1'b0;
    cfg_sel  = 2'b00;
    cfg_data = 16'd0;
    edge_clr = 1'b0;
    set_pins(4'b0000);

    // Reset defaults
    tick(5);
    check("rst_out", OUT, 0);
    check("rst_edge_count", edge_count, 0);
    check("rst_state", state_o, 0);

    rst_n = 1'b1;
    set_pins(4'b1100);
    tick(2);
    check("rel_still_off", state_o, 0);
    tick(1);
    check("rel_settle", state_o, 1);
    tick(99);
    check("settle_last_cycle", state_o, 1);
    tick(1);
    check("enter_run", state_o, 2);
    tick(199);
    check("red_before_rise", OUT, 0);
    tick(1);
    check("red_first_rise", OUT, 1);
    check("red_edge_count_1", edge_count, 1);
    tick(199);
    check("red_high_end", OUT, 1);
    tick(1);
    check("red_fall", OUT, 0);
    wait_level("red_low", 1'b1, 1000, n);
    check("red_low", n, 200);
    check("red_edge_count_2", edge_count, 2);

    // Filter sweep at 100% with default half-periods
    run_channel("blue", 4'b1101, 150);
    run_channel("clear", 4'b1110, 80);
    run_channel("green", 4'b1111, 250);

    // Dark channel and power-down
    cfg_write(2'd3, 16'd0);
    set_pins(4'b1110);
    tick(3);
    check("to_clear_settle", state_o, 1);
    set_pins(4'b1111);
    edge_clr = 1'b1;
    tick(1);
    edge_clr = 1'b0;
    tick(2);
    check("dark_settle", state_o, 1);
    check("dark_clr", edge_count, 0);
    tick(100);
    check("dark_run", state_o, 2);
    tick(300);
    check("dark_out", OUT, 0);
    check("dark_edge_frozen", edge_count, 0);
    check("dark_still_run", state_o, 2);
    set_pins(4'b0011);
    tick(2);
    check("pd_latency", state_o, 2);
    tick(1);
    check("pd_off", state_o, 0);
    check("pd_out", OUT, 0);

    // Scaling: red half 10 at 2% then 20%
    cfg_write(2'd0, 16'd10);
    set_pins(4'b0100);
    tick(3);
    check("s2_settle", state_o, 1);
    tick(100);
    check("s2_run", state_o, 2);
    wait_level("s2_first_rise", 1'b1, 2000, n);
    check("s2_first_rise", n, 500);
    wait_level("s2_high", 1'b0, 2000, n);
    check("s2_high", n, 500);
    wait_level("s2_low", 1'b1, 2000, n);
    check("s2_low", n, 500);
    set_pins(4'b1000);
    tick(2);
    check("s20_out_before", OUT, 1);
    tick(1);
    check("s20_out_forced", OUT, 0);
    check("s20_settle", state_o, 1);
    tick(100);
    check("s20_run", state_o, 2);
    wait_level("s20_first_rise", 1'b1, 500, n);
    check("s20_first_rise", n, 50);
    wait_level("s20_high", 1'b0, 500, n);
    check("s20_high", n, 50);
    wait_level("s20_low", 1'b1, 500, n);
    check("s20_low", n, 50);

    // Mid-run write on blue
    run_channel("blue2", 4'b1101, 150);
    wait_level("blue2_low", 1'b1, 1000, n);
    check("blue2_low", n, 150);
    tick(20);
    cfg_write(2'd1, 16'd50);
    wait_level("mid_high_rest", 1'b0, 1000, n);
    check("mid_high_rest", n, 129);
    wait_level("mid_low_new", 1'b1, 1000, n);
    check("mid_low_new", n, 50);
    wait_level("mid_high_new", 1'b0, 1000, n);
    check("mid_high_new", n, 50);
    tick(49);
    check("clr_pre_out", OUT, 0);
    edge_clr = 1'b1;
    tick(1);
    edge_clr = 1'b0;
    check("clr_rise_out", OUT, 1);
    check("clr_beats_rise", edge_count, 0);
    wait_level("after_clr_high", 1'b0, 500, n);
    wait_level("after_clr_low", 1'b1, 500, n);
    check("after_clr_count", edge_count, 1);

    // Reset mid-operation
    cfg_write(2'd0, 16'd7);
    check("prereset_out_high", OUT, 1);
    rst_n = 1'b0;
    tick(1);
    check("mid_rst_out", OUT, 0);
    check("mid_rst_edge_count", edge_count, 0);
    check("mid_rst_state", state_o, 0);
    cfg_write(2'd0, 16'd9);
    tick(1);
    rst_n = 1'b1;
    run_channel("red_after_rst", 4'b1100, 200);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed simulation still running expected finish");
    $fatal(1, "timeout");
  end

endmodule
